// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, its FIFO and the bus wrapper.
package uart_pkg;

  localparam int UART_PAYLOAD_BITS  = 8;
  localparam int UART_RX_FIFO_DEPTH = 4;

  function automatic bit uart_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x PAYLOAD_BITS register array, sync write, async read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH        = UART_RX_FIFO_DEPTH,
  localparam int ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [ADDR_BITS-1:0]    waddr_i,
  input  logic [PAYLOAD_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0]    raddr_i,
  output logic [PAYLOAD_BITS-1:0] rdata_o
);

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: drains the receiver, FWFT output, level, sticky overrun.
// Define UART_RX_FIFO_OVERWRITE_EN to drop the oldest byte on overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH        = UART_RX_FIFO_DEPTH,
  localparam int ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_read,
  output logic [PAYLOAD_BITS-1:0] data_out,
  output logic                    data_valid,
  input  logic                    data_read,
  output logic [ADDR_BITS:0]      level,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam logic [ADDR_BITS-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_BITS:0]   LVL_ONE  = 1;
  localparam logic [ADDR_BITS:0]   LVL_FULL = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic                 overrun_q, overrun_d;

  logic full, empty, pop, push, ovf, we;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign pop     = data_read & ~empty;
  // A pop frees a slot in the same cycle, so full+pop still accepts.
  assign push    = rx_valid & (~full | pop);
  assign ovf     = rx_valid & full & ~pop;
  assign rx_read = rx_valid;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  assign we = resetn & (push | ovf);
`else
  assign we = resetn & push;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef UART_RX_FIFO_OVERWRITE_EN
    if (ovf) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
`endif
    unique case (1'b1)
      push & ~pop: level_d = level_q + LVL_ONE;
      pop & ~push: level_d = level_q - LVL_ONE;
      default:     level_d = level_q;
    endcase
    if (ovf)              overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH        (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign data_valid = ~empty;
  assign level      = level_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=4, 8-bit payload).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_read;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_read;
  logic [2:0] level;
  logic       overrun;
  logic       overrun_clr;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_read     (rx_read),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_read   (data_read),
    .level       (level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk({tag, "_dv"}, int'(data_valid), 1);
    chk(tag, int'(data_out), int'(exp));
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    rx_valid    = 1'b1;
    rx_data     = 8'h33;
    data_read   = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    chk("rst_level", int'(level), 0);
    chk("rst_dv", int'(data_valid), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_rx_read", int'(rx_read), 1);
    rx_valid = 1'b0;
    resetn   = 1'b1;
    tick();

    // single byte
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    #1;
    chk("single_rx_read", int'(rx_read), 1);
    tick();
    rx_valid = 1'b0;
    chk("single_dv", int'(data_valid), 1);
    chk("single_data", int'(data_out), 8'hA5);
    chk("single_level", int'(level), 1);
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    chk("single_pop_level", int'(level), 0);
    chk("single_pop_dv", int'(data_valid), 0);

    // read while empty is ignored
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    chk("empty_read_level", int'(level), 0);

    // fill and wrap
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("fill_level", int'(level), 4);
    pop("wrap_pop1", 8'h01);
    pop("wrap_pop2", 8'h02);
    chk("wrap_level2", int'(level), 2);
    push(8'h05);
    push(8'h06);
    chk("wrap_level4", int'(level), 4);
    pop("wrap_pop3", 8'h03);
    pop("wrap_pop4", 8'h04);
    pop("wrap_pop5", 8'h05);
    pop("wrap_pop6", 8'h06);
    chk("wrap_end_level", int'(level), 0);
    chk("wrap_end_dv", int'(data_valid), 0);
    chk("wrap_ovr", int'(overrun), 0);

    // overflow
    for (int i = 1; i <= 4; i++) push(8'(i));
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    #1;
    chk("ovf_rx_read", int'(rx_read), 1);
    tick();
    rx_valid = 1'b0;
    chk("ovf_ovr", int'(overrun), 1);
    chk("ovf_level", int'(level), 4);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    chk("ovf_head", int'(data_out), 8'h02);
    pop("ovf_pop1", 8'h02);
    pop("ovf_pop2", 8'h03);
    pop("ovf_pop3", 8'h04);
    pop("ovf_pop4", 8'h55);
`else
    pop("ovf_pop1", 8'h01);
    pop("ovf_pop2", 8'h02);
    pop("ovf_pop3", 8'h03);
    pop("ovf_pop4", 8'h04);
`endif
    chk("ovf_end_level", int'(level), 0);
    chk("ovf_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovf_clr", int'(overrun), 0);

    // full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push(8'(i));
    rx_valid  = 1'b1;
    rx_data   = 8'h77;
    data_read = 1'b1;
    tick();
    rx_valid  = 1'b0;
    data_read = 1'b0;
    chk("fullpp_level", int'(level), 4);
    chk("fullpp_ovr", int'(overrun), 0);
    pop("fullpp_pop1", 8'h02);
    pop("fullpp_pop2", 8'h03);
    pop("fullpp_pop3", 8'h04);
    pop("fullpp_tail", 8'h77);
    chk("fullpp_end_level", int'(level), 0);

    // empty with simultaneous push and pop
    rx_valid  = 1'b1;
    rx_data   = 8'h88;
    data_read = 1'b1;
    tick();
    rx_valid  = 1'b0;
    data_read = 1'b0;
    chk("emptypp_level", int'(level), 1);
    pop("emptypp_data", 8'h88);
    chk("emptypp_end_level", int'(level), 0);

    // clear coinciding with a new overflow: set wins
    for (int i = 1; i <= 4; i++) push(8'(8'h10 + i));
    rx_valid    = 1'b1;
    rx_data     = 8'h99;
    overrun_clr = 1'b1;
    tick();
    rx_valid    = 1'b0;
    overrun_clr = 1'b0;
    chk("setclr_ovr", int'(overrun), 1);
    chk("setclr_level", int'(level), 4);

    // reset mid-stream
    resetn   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    #1;
    chk("midrst_rx_read", int'(rx_read), 1);
    tick();
    chk("midrst_level", int'(level), 0);
    chk("midrst_dv", int'(data_valid), 0);
    chk("midrst_ovr", int'(overrun), 0);
    rx_valid = 1'b0;
    resetn   = 1'b1;
    tick();
    push(8'h42);
    chk("post_rst_level", int'(level), 1);
    chk("post_rst_data", int'(data_out), 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Drains each completed byte from the receiver's valid/read handshake into a small synchronous FIFO, so the receiver returns to idle within one cycle and is never stalled.
- Presents a first-word-fall-through byte stream to the CPU/peripheral bus, with fill level and a sticky overrun flag.

Parameters:
- PAYLOAD_BITS, 8, width of each received byte (matches the receiver payload width).
- DEPTH, 4, FIFO entries. Must be a power of two, >= 2.
- ADDR_BITS, $clog2(DEPTH), localparam, pointer index width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  active-low reset.
- rx_valid  in  1  receiver has a completed byte.
- rx_data  in  PAYLOAD_BITS  receiver byte.
- rx_read  out  1  byte consumed; receiver clears its valid.
- data_out  out  PAYLOAD_BITS  head-of-FIFO byte.
- data_valid  out  1  FIFO not empty.
- data_read  in  1  pop the head byte.
- level  out  ADDR_BITS+1  current entry count, 0..DEPTH.
- overrun  out  1  sticky: a received byte was lost.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on resetn; all state updates on posedge clk.
- Reset values:
  - rd_ptr = wr_ptr = 0, level = 0, data_valid = 0, overrun = 0.
  - data_out is don't-care while data_valid = 0. Memory contents are not reset.
- Receiver drain:
  - rx_read = rx_valid, combinational.
  - Every cycle with rx_valid = 1 is a push attempt. The receiver deasserts valid on the following cycle, so each byte is seen exactly once.
- Push when not full: mem[wr_ptr] <= rx_data; wr_ptr increments, wrapping modulo DEPTH.
- Pop: when data_read = 1 and level > 0, rd_ptr increments, wrapping. data_read while empty is ignored (no pointer or level change).
- Push and pop in the same cycle:
  - Not empty: both occur, level unchanged.
  - Full: the pop frees a slot, the push is accepted, level stays DEPTH, no overrun.
  - Empty: the push occurs, the pop is ignored, level becomes 1.
- Full with no pop and rx_valid = 1: rx_read is still asserted. The overflow action follows Optional Feature, and overrun <= 1.
- Latency:
  - A byte pushed on edge N is visible on data_out with data_valid = 1 after edge N.
  - data_out = mem[rd_ptr] combinationally (first-word-fall-through).
- level:
  - Registered: +1 on push only, -1 on pop only, unchanged otherwise.
  - Full is level == DEPTH; empty is level == 0.
  - Pointers carry no wrap bit; level alone disambiguates full and empty.
- overrun:
  - Set has priority over overrun_clr in the same cycle.
  - Otherwise overrun_clr = 1 clears it.
- Reset mid-stream (resetn low while rx_valid high): all state returns to reset values. rx_read still follows rx_valid, so the receiver is not left stuck in its ready state.

Optional Feature:
- Macro: UART_RX_FIFO_OVERWRITE_EN.
- Without the macro: on overflow the incoming byte is discarded; FIFO contents and pointers are unchanged.
- With the macro: on overflow the oldest entry is dropped. The new byte is written at wr_ptr, and both wr_ptr and rd_ptr increment. level stays DEPTH and data_out advances to the next-oldest byte.
- overrun sets in both variants.

Decomposition:
- Shared package (uart_pkg): UART_PAYLOAD_BITS default (8) and UART_RX_FIFO_DEPTH default (4), shared with the receiver and the bus wrapper.
- One sub-module: uart_fifo_mem.
  - Parameterised DEPTH x PAYLOAD_BITS register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr -> rdata).
- Pointer, level and flag logic stays in uart_rx_fifo.

Test Plan:
- Reset: resetn=0 for 2 cycles with rx_valid=1 -> level=0, data_valid=0, overrun=0, rx_read=1.
- Single byte: rx_valid pulse with rx_data=0xA5 -> rx_read=1 the same cycle; next cycle data_valid=1, data_out=0xA5, level=1. Then data_read pulse -> level=0, data_valid=0.
- Fill and wrap: push 0x01..0x04 (DEPTH=4) -> level=4. Pop two, push 0x05, 0x06, pop all -> order 0x01..0x06, pointers wrapped, overrun=0.
- Overflow, default build: full with 0x01..0x04, push 0x55 -> overrun=1, level=4, pop order 0x01..0x04. Then overrun_clr=1 -> overrun=0.
- Overflow with UART_RX_FIFO_OVERWRITE_EN: same stimulus -> overrun=1, level=4, data_out=0x02, pop order 0x02, 0x03, 0x04, 0x55.
- Simultaneous events:
  - Full, with push 0x77 and data_read in the same cycle -> level=4, overrun=0, tail=0x77.
  - Empty, with push and data_read in the same cycle -> level=1.
  - overrun_clr coinciding with a new overflow -> overrun stays 1.
